// File: rtl/sram_responder_if.sv
// Read/write handshake bundle for sram_responder.
// slave  : the responder side (drives ready/response signals)
// master : the initiator side (drives requests, takes responses)
interface sram_responder_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0]   araddr;
    logic               arvalid;
    logic               arready;
    logic [WIDTH-1:0]   rdata;
    logic [1:0]         rresp;
    logic               rvalid;
    logic               rready;
    logic [WIDTH-1:0]   awaddr;
    logic               awvalid;
    logic               awready;
    logic [WIDTH-1:0]   wdata;
    logic [WIDTH/8-1:0] wstrb;
    logic               wvalid;
    logic               wready;
    logic [1:0]         bresp;
    logic               bvalid;
    logic               bready;

    modport slave (
        input  araddr, arvalid, rready,
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid,
        output awready, wready, bresp, bvalid
    );

    modport master (
        output araddr, arvalid, rready,
        output awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid,
        input  awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/sram_responder.sv
// Single-outstanding SRAM responder behind a read/write handshake bus.
// One transaction at a time; reads win over simultaneous writes.
// Optional feature macro: SRAM_RESPONDER_RAND_DELAY_EN adds an LFSR-driven
// 0..3 cycle jitter on top of LATENCY.
module sram_responder #(
    parameter int               WIDTH      = 32,
    parameter int               DEPTH_LOG2 = 10,
    parameter logic [WIDTH-1:0] BASE       = 32'h8000_0000,
    parameter int               LATENCY    = 1
) (
    input  logic              clk,
    input  logic              rst,
    sram_responder_if.slave   bus
);
    localparam int               DEPTH = 1 << DEPTH_LOG2;
    localparam int               NB    = WIDTH / 8;
    localparam int               CW    = $clog2(LATENCY + 4);
    // Byte span of the mapped window; one extra bit so it never overflows.
    localparam logic [WIDTH:0]   SPAN  = (WIDTH+1)'(1) << (DEPTH_LOG2 + 2);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD_WAIT = 3'd1;
    localparam logic [2:0] RD_RESP = 3'd2;
    localparam logic [2:0] WR_WAIT = 3'd3;
    localparam logic [2:0] WR_RESP = 3'd4;

    logic [WIDTH-1:0]      mem [DEPTH];

    logic [2:0]            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [CW-1:0]         eff_lat;
    logic [DEPTH_LOG2-1:0] rd_idx_q;
    logic                  rd_oor_q;
    logic                  wr_err_q;
    logic [WIDTH-1:0]      rdata_q;
    logic [1:0]            rresp_q, bresp_q;

    // Offsets below BASE wrap to huge values and so fall out of range too.
    logic [WIDTH-1:0]      ar_off, aw_off;
    logic                  ar_in, aw_in;
    logic                  rd_acc, wr_acc;

    assign ar_off = bus.araddr - BASE;
    assign aw_off = bus.awaddr - BASE;
    assign ar_in  = {1'b0, ar_off} < SPAN;
    assign aw_in  = {1'b0, aw_off} < SPAN;

    assign rd_acc = (state_q == IDLE) && bus.arvalid;
    assign wr_acc = (state_q == IDLE) && !bus.arvalid && bus.awvalid && bus.wvalid;

`ifdef SRAM_RESPONDER_RAND_DELAY_EN
    logic [7:0] lfsr_q;

    // Free-running Fibonacci LFSR, taps 8,6,5,4.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) lfsr_q <= 8'h5A;
        else      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    assign eff_lat = CW'(LATENCY) + CW'(lfsr_q[1:0]);
`else
    assign eff_lat = CW'(LATENCY);
`endif

    // Next-state and wait-counter logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (rd_acc) begin
                    state_d = RD_WAIT;
                    cnt_d   = eff_lat;
                end else if (wr_acc) begin
                    state_d = WR_WAIT;
                    cnt_d   = eff_lat;
                end
            end
            RD_WAIT: begin
                if (cnt_q == '0) state_d = RD_RESP;
                else             cnt_d   = cnt_q - CW'(1);
            end
            WR_WAIT: begin
                if (cnt_q == '0) state_d = WR_RESP;
                else             cnt_d   = cnt_q - CW'(1);
            end
            RD_RESP: if (bus.rready) state_d = IDLE;
            WR_RESP: if (bus.bready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM, captured request attributes and registered responses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rd_idx_q <= '0;
            rd_oor_q <= 1'b0;
            wr_err_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= 2'b00;
            bresp_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (rd_acc) begin
                rd_idx_q <= ar_off[DEPTH_LOG2+1:2];
                rd_oor_q <= !ar_in;
            end
            if (wr_acc) wr_err_q <= !aw_in;
            // Read data is sampled on the edge that enters RD_RESP.
            if (state_q == RD_WAIT && cnt_q == '0) begin
                rdata_q <= rd_oor_q ? '0 : mem[rd_idx_q];
                rresp_q <= rd_oor_q ? 2'b10 : 2'b00;
            end
            if (state_q == WR_WAIT && cnt_q == '0)
                bresp_q <= wr_err_q ? 2'b10 : 2'b00;
        end
    end

    // Storage: byte-masked commit at write acceptance; never reset.
    always_ff @(posedge clk) begin
        if (rst && wr_acc && aw_in) begin
            for (int b = 0; b < NB; b++)
                if (bus.wstrb[b])
                    mem[aw_off[DEPTH_LOG2+1:2]][8*b +: 8] <= bus.wdata[8*b +: 8];
        end
    end

    assign bus.arready = (state_q == IDLE);
    assign bus.awready = wr_acc;
    assign bus.wready  = wr_acc;
    assign bus.rvalid  = (state_q == RD_RESP);
    assign bus.bvalid  = (state_q == WR_RESP);
    assign bus.rdata   = rdata_q;
    assign bus.rresp   = rresp_q;
    assign bus.bresp   = bresp_q;
endmodule
